// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone classic initiator.
// Imported by the bus master and anything that talks to it.
package wb_pkg;

  typedef logic [15:0] adr_t;
  typedef logic [15:0] dat_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } wb_mst_state_t;

  localparam int WB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/if_wb.sv
// Wishbone classic bus bundle for the 64k x 16 RAM slave.
// dat_i carries write data toward the slave, dat_o carries read data back.
interface if_wb (
  input logic clk,
  input logic rst
);

  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        ack;

  modport master (
    input  clk,
    input  rst,
    input  ack,
    input  dat_o,
    output cyc,
    output stb,
    output we,
    output adr,
    output dat_i
  );

  modport slave (
    input  clk,
    input  rst,
    input  cyc,
    input  stb,
    input  we,
    input  adr,
    input  dat_i,
    output dat_o,
    output ack
  );

endinterface

// File: rtl/wb_master_standard.sv
// Wishbone classic standard-cycle initiator: one bus cycle per command.
// Optional ack watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_standard
  import wb_pkg::*;
#(
  parameter int timeout = WB_TIMEOUT_DEFAULT
) (
  if_wb.master        wb,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [15:0] cmd_adr,
  input  logic [15:0] cmd_dat,
  output logic        rsp_valid,
  output logic [15:0] rsp_dat,
  output logic        rsp_err
);

  if (timeout < 1 || timeout > 65535) begin : g_bad_timeout
    $error("wb_master_standard: timeout out of range");
  end

  wb_mst_state_t state_q, state_d;

  logic cyc_q, cyc_d;
  logic stb_q, stb_d;
  logic we_q, we_d;
  adr_t adr_q, adr_d;
  dat_t wdat_q, wdat_d;
  logic rsp_valid_q, rsp_valid_d;
  dat_t rsp_dat_q, rsp_dat_d;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(timeout - 1);

  logic [15:0] wd_q, wd_d;
  logic        rsp_err_q, rsp_err_d;
`endif

  assign cmd_ready = (state_q == IDLE) && !wb.rst;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
`ifdef WB_MASTER_TIMEOUT_EN
    wd_d        = wd_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          we_d    = cmd_we;
          wdat_d  = cmd_we ? cmd_dat : '0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      BUS: begin
        // ack wins over watchdog expiry on the same edge
        if (wb.ack) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : wb.dat_o;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (wd_q == WD_LAST) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
        end else begin
          wd_d        = wd_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb.clk) begin
    if (wb.rst) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      wd_q        <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
`ifdef WB_MASTER_TIMEOUT_EN
      wd_q        <= wd_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign wb.cyc    = cyc_q;
  assign wb.stb    = stb_q;
  assign wb.we     = we_q;
  assign wb.adr    = adr_q;
  assign wb.dat_i  = wdat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;

`ifdef WB_MASTER_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_standard.sv
// Directed bench for wb_master_standard against a registered-ack RAM slave.
// Build with WB_MASTER_TIMEOUT_EN to exercise the watchdog (timeout=4).
module tb_wb_master_standard;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [15:0] cmd_adr = '0;
  logic [15:0] cmd_dat = '0;
  logic        rsp_valid;
  logic [15:0] rsp_dat;
  logic        rsp_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_wb bus (.clk(clk), .rst(rst));

  wb_master_standard #(.timeout(TO)) dut (
    .wb       (bus),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err)
  );

  // RAM slave: ack registered after w_cfg extra wait cycles
  logic [15:0] mem [0:65535];
  logic        s_ack = 1'b0;
  logic [15:0] s_dat = '0;
  logic [7:0]  s_cnt = '0;
  logic [7:0]  w_cfg = '0;
  logic        no_ack = 1'b0;
  logic        force_ack = 1'b0;

  assign bus.ack   = s_ack | force_ack;
  assign bus.dat_o = s_dat;

  always @(posedge clk) begin
    if (rst || !(bus.cyc && bus.stb) || s_ack) begin
      s_ack <= 1'b0;
      s_cnt <= '0;
    end else if (!no_ack && s_cnt == w_cfg) begin
      s_ack <= 1'b1;
      if (bus.we) mem[bus.adr] <= bus.dat_i;
      else s_dat <= mem[bus.adr];
    end else begin
      s_cnt <= s_cnt + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic we, input logic [15:0] adr,
                         input logic [15:0] dat, output logic [15:0] rd,
                         output logic err, output int lat, output int stbs);
    int n;
    cmd_we = we;
    cmd_adr = adr;
    cmd_dat = dat;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    step();
    cmd_valid = 1'b0;
    chk("bus_adr", 32'(bus.adr), 32'(adr));
    chk("bus_we", 32'(bus.we), 32'(we));
    chk("bus_dat_i", 32'(bus.dat_i), we ? 32'(dat) : 32'd0);
    lat = 0;
    stbs = 0;
    while (!rsp_valid && lat < 200) begin
      stbs += int'(bus.stb);
      step();
      lat++;
    end
    rd = rsp_dat;
    err = rsp_err;
    if (!rsp_valid) begin
      chk("rsp_arrived", 32'd0, 32'd1);
    end else begin
      chk("ready_with_rsp", 32'(cmd_ready), 32'd1);
      chk("stb_low_after_ack", 32'(bus.stb), 32'd0);
      step();
      chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      chk("no_second_stb", 32'(bus.stb), 32'd0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [15:0] rd;
    logic        err;
    int          lat;
    int          stbs;
    int          acc [4];
    int          k;
    int          pulses;
    int          acks;
    logic        acc_now;

    step();
    step();
    chk("rst_cyc", 32'(bus.cyc), 32'd0);
    chk("rst_stb", 32'(bus.stb), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_adr", 32'(bus.adr), 32'd0);
    chk("rst_dat_i", 32'(bus.dat_i), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_dat", 32'(rsp_dat), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_ready_low", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // write then read, no wait states
    w_cfg = 8'd0;
    run_cmd(1'b1, 16'h0010, 16'hBEEF, rd, err, lat, stbs);
    chk("w0_wr_lat", 32'(lat), 32'd2);
    chk("w0_wr_stb", 32'(stbs), 32'd2);
    chk("w0_wr_dat", 32'(rd), 32'd0);
    chk("w0_wr_err", 32'(err), 32'd0);
    run_cmd(1'b0, 16'h0010, 16'h5555, rd, err, lat, stbs);
    chk("w0_rd_lat", 32'(lat), 32'd2);
    chk("w0_rd_stb", 32'(stbs), 32'd2);
    chk("w0_rd_dat", 32'(rd), 32'hBEEF);
    chk("w0_rd_err", 32'(err), 32'd0);

`ifdef WB_MASTER_TIMEOUT_EN
    // ack lands exactly on the expiry edge
    w_cfg = 8'd2;
    run_cmd(1'b1, 16'hFFFF, 16'h1234, rd, err, lat, stbs);
    chk("to_wr_lat", 32'(lat), 32'd4);
    chk("to_wr_err", 32'(err), 32'd0);
    run_cmd(1'b0, 16'hFFFF, 16'h0000, rd, err, lat, stbs);
    chk("to_ack4_lat", 32'(lat), 32'd4);
    chk("to_ack4_err", 32'(err), 32'd0);
    chk("to_ack4_dat", 32'(rd), 32'h1234);
    // slave never answers
    no_ack = 1'b1;
    run_cmd(1'b0, 16'hFFFF, 16'h0000, rd, err, lat, stbs);
    chk("to_abort_stb", 32'(stbs), 32'd4);
    chk("to_abort_lat", 32'(lat), 32'd4);
    chk("to_abort_err", 32'(err), 32'd1);
    chk("to_abort_dat", 32'(rd), 32'd0);
    no_ack = 1'b0;
`else
    w_cfg = 8'd3;
    run_cmd(1'b1, 16'hFFFF, 16'h1234, rd, err, lat, stbs);
    chk("w3_wr_lat", 32'(lat), 32'd5);
    run_cmd(1'b0, 16'hFFFF, 16'h0000, rd, err, lat, stbs);
    chk("w3_rd_lat", 32'(lat), 32'd5);
    chk("w3_rd_stb", 32'(stbs), 32'd5);
    chk("w3_rd_dat", 32'(rd), 32'h1234);
    chk("w3_rd_err", 32'(err), 32'd0);
    // long wait: no watchdog in this build
    w_cfg = 8'd20;
    run_cmd(1'b0, 16'hFFFF, 16'h0000, rd, err, lat, stbs);
    chk("w20_rd_lat", 32'(lat), 32'd22);
    chk("w20_rd_err", 32'(err), 32'd0);
    chk("w20_rd_dat", 32'(rd), 32'h1234);
`endif

    // back-to-back writes with cmd_valid held
    w_cfg = 8'd0;
    k = 0;
    pulses = 0;
    acks = 0;
    cmd_we = 1'b1;
    cmd_adr = 16'd0;
    cmd_dat = 16'hA000;
    cmd_valid = 1'b1;
    for (int t = 0; t < 30; t++) begin
      acc_now = cmd_valid && cmd_ready;
      step();
      if (acc_now) begin
        acc[k] = t;
        k++;
        if (k == 4) begin
          cmd_valid = 1'b0;
        end else begin
          cmd_adr = 16'(k);
          cmd_dat = 16'hA000 + 16'(k);
        end
      end
      pulses += int'(rsp_valid);
      acks += int'(bus.ack);
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", 32'(k), 32'd4);
    chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd3);
    chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd3);
    chk("b2b_gap3", 32'(acc[3] - acc[2]), 32'd3);
    chk("b2b_rsp", 32'(pulses), 32'd4);
    chk("b2b_acks", 32'(acks), 32'd4);
    for (int i = 0; i < 4; i++) begin
      run_cmd(1'b0, 16'(i), 16'h0000, rd, err, lat, stbs);
      chk("b2b_readback", 32'(rd), 32'hA000 + 32'(i));
    end

    // reset while the cycle is in flight
    w_cfg = 8'd3;
    cmd_we = 1'b0;
    cmd_adr = 16'h0010;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("rb_cyc_up", 32'(bus.cyc), 32'd1);
    rst = 1'b1;
    step();
    chk("rb_cyc", 32'(bus.cyc), 32'd0);
    chk("rb_stb", 32'(bus.stb), 32'd0);
    chk("rb_rsp", 32'(rsp_valid), 32'd0);
    chk("rb_ready_in_rst", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rb_ready_after", 32'(cmd_ready), 32'd1);
    pulses = 0;
    acks = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      pulses += int'(rsp_valid);
      acks += int'(bus.cyc);
    end
    chk("rb_no_rsp", 32'(pulses), 32'd0);
    chk("rb_no_cyc", 32'(acks), 32'd0);

    // spurious ack in IDLE
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    pulses = 0;
    acks = 0;
    for (int t = 0; t < 4; t++) begin
      pulses += int'(rsp_valid);
      acks += int'(bus.cyc);
      step();
    end
    chk("sp_no_rsp", 32'(pulses), 32'd0);
    chk("sp_no_cyc", 32'(acks), 32'd0);
    chk("sp_ready", 32'(cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_master_standard.md
Name: wb_master_standard

Overview:
- Wishbone classic standard-cycle initiator; the requester-side counterpart of the 64k x 16 RAM slave.
- Accepts single read/write commands on a valid/ready command port and runs one classic cycle per command.
- Holds cyc/stb until ack, then returns read data and status on a one-cycle response strobe.
- Sits between local control logic (CPU/DMA/test sequencer) and the if_wb bus.

Parameters:
- timeout, 16, ack watchdog limit in clocks counted from stb assertion; used only when WB_MASTER_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- wb.clk  input  1  bus clock, carried in if_wb; all logic on posedge.
- wb.rst  input  1  synchronous active-high reset, carried in if_wb.
- wb  if_wb.master  -  drives wb.cyc, wb.stb, wb.we, wb.adr[15:0], wb.dat_i[15:0] (write data toward slave); samples wb.ack and wb.dat_o[15:0] (read data).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_adr  input  16  word address.
- cmd_dat  input  16  write data; ignored for reads.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_dat  output  16  read data; 0 for writes and errors.
- rsp_err  output  1  timeout abort; constant 0 without the feature.

Behaviour:
- Reset: synchronous, active-high on wb.clk; wins over every other event.
- Reset values: cyc=stb=we=0, adr=0, dat_i=0, rsp_valid=0, rsp_dat=0, rsp_err=0, state IDLE, watchdog counter 0.
- State IDLE: cmd_ready = 1 (combinational from state; 0 while wb.rst is high).
  - Command accepted on an edge where cmd_valid && cmd_ready.
  - On acceptance, register adr/we; dat_i = cmd_dat for writes, 0 for reads.
  - After that edge, cyc=stb=1 and state = BUS.
- State BUS: cmd_ready = 0; cyc, stb, we, adr, dat_i held stable; commands not accepted.
  - On the edge where wb.ack is sampled high: cyc=stb=we=0 after that edge and state = IDLE.
  - rsp_valid=1 for exactly one cycle; rsp_dat = wb.dat_o if read, else 0; rsp_err=0.
  - adr and dat_i keep their last values.
- Latency against a slave with W wait cycles:
  - rsp_valid is high 2+W cycles after the acceptance edge.
  - cmd_ready is high in the same cycle as rsp_valid.
  - A back-to-back command gets cyc again one cycle later: minimum 3+W cycles per transfer.
  - No spurious second ack: stb is low on the edge after ack.
- wb.ack sampled in IDLE is ignored: no response, no state change.
- rsp_valid has no backpressure; the consumer must take it in that cycle.
- Reset during BUS: cycle abandoned, cyc/stb low after the reset edge, no response emitted.
- Every output is a flop except cmd_ready.

Optional Feature:
- WB_MASTER_TIMEOUT_EN defined:
  - 16-bit counter cleared on acceptance, increments each cycle in BUS.
  - If ack is not sampled and the counter reaches timeout-1: abort the cycle (cyc/stb low next edge, state IDLE).
  - The abort raises rsp_valid=1, rsp_err=1, rsp_dat=0.
  - Ack sampled on the expiry edge takes priority: normal response, rsp_err=0.
- Not defined: no counter; BUS waits indefinitely for ack; rsp_err tied 0.

Decomposition:
- Package wb_pkg:
  - adr_t (logic [15:0]), dat_t (logic [15:0]).
  - state enum wb_mst_state_t {IDLE, BUS}.
  - default timeout constant WB_TIMEOUT_DEFAULT = 16.
- No sub-module: the FSM and watchdog counter are inline.

Test Plan:
- Write then read, RAM slave W=0:
  - cmd write adr=16'h0010 dat=16'hBEEF, then read adr=16'h0010.
  - Expect cyc/stb high exactly 2 cycles each.
  - Read rsp_dat=16'hBEEF, rsp_err=0, rsp_valid 2 cycles after each acceptance.
- Wait states, W=3:
  - Read adr=16'hFFFF after writing 16'h1234.
  - Expect rsp_valid 5 cycles after acceptance and rsp_dat=16'h1234.
- Back-to-back, W=0:
  - cmd_valid held high for 4 writes to adr 0..3.
  - Expect one ack per cycle, accepts every 3 cycles, 4 rsp_valid pulses.
  - Read-back returns the written data.
- Reset in BUS:
  - Assert wb.rst one cycle after acceptance.
  - Expect cyc=stb=0 after that edge, no rsp_valid, cmd_ready=1 after rst drops.
- Spurious ack:
  - Force wb.ack=1 for one cycle in IDLE.
  - Expect no rsp_valid and no cyc.
- Timeout (WB_MASTER_TIMEOUT_EN, timeout=4):
  - Slave never acks.
  - Expect stb high 4 cycles, then rsp_valid=1, rsp_err=1, rsp_dat=0.
  - Ack on cycle 4 instead gives rsp_err=0.
